mem_access: RTL and testbench
=============================

# mem_access

Load/store unit for the memory stage of the core: sits directly downstream of the instruction control decoder and consumes its memory-side controls (memtoreg, memwrite, load size/sign, store size). Performs each load or store as a sequence of byte beats on a byte-wide request/acknowledge bus, assembles and sign/zero-extends load data, and stalls the pipeline while the access is in flight.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, register data width (fixed at 32; four byte lanes)
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  memory-stage instruction valid this cycle
- i_memtoreg  in  1  access is a load
- i_memwrite  in  1  access is a store
- i_insize  in  2  load size code
- i_insign  in  1  load is sign-extended
- i_outsize  in  2  store size code
- i_addr  in  ADDR_W  effective byte address
- i_wdata  in  32  store data (low bytes used)
- o_busy  out  1  stall request to pipeline
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load result, valid with o_done
- o_fault  out  1  one-cycle misalignment pulse (macro-dependent)
- o_bus_req  out  1  bus beat request
- o_bus_we  out  1  beat is a write
- o_bus_addr  out  ADDR_W  beat byte address
- o_bus_wdata  out  8  beat write byte
- i_bus_rdata  in  8  beat read byte, valid with i_bus_ack
- i_bus_ack  in  1  beat accepted this cycle

## Operation
- Size codes (2 bits): 1 = byte, 2 = halfword, 0 = word. Beat count N = 1, 2, 4.
- States: IDLE, XFER, DONE.
- IDLE: i_start sampled high -> latch addr, wdata, size, sign, direction; beat counter = 0; go XFER. Neither memtoreg nor memwrite -> go DONE directly, no bus activity, o_rdata = 0. Both set -> treated as store.
- XFER: o_bus_req = 1, o_bus_addr = base + counter, o_bus_we = store, o_bus_wdata = byte[counter] of latched wdata (little-endian). Edge with i_bus_ack = 1 completes beat: load stores i_bus_rdata into byte lane [counter]; counter increments. Completion of beat N-1 -> DONE.
- DONE: o_done = 1 for exactly one cycle; o_rdata = extended load data (store: 0); -> IDLE.
- Extension: byte/half with insign=1 replicate bit 7/15 to bit 31; insign=0 zero-fill; word unchanged.
- i_start ignored outside IDLE. Inputs other than i_bus_* are don't-care after latching.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- o_busy = (state != IDLE), combinational from state; also high in the cycle i_start is sampled in IDLE for a non-empty access (combinational i_start term) so the pipeline holds.
- Latency with i_bus_ack tied high: start at edge k -> req high cycles k+1..k+N, o_done in cycle k+N+1. Each stall cycle of ack adds one.
- o_bus_req stays high across consecutive beats; addr/wdata change only the cycle after an acked edge; stable while ack low.
- Reset values: state IDLE, counter 0, o_busy 0, o_done 0, o_fault 0, o_rdata 0, o_bus_req 0, o_bus_we 0, o_bus_addr 0, o_bus_wdata 0.
- Reset mid-transfer: next cycle all outputs at reset values; partial beats abandoned; no o_done.

## Configuration
- MEMACC_ALIGN_CHECK_EN defined: in IDLE, start of half with addr[0]=1 or word with addr[1:0]!=0 -> no bus beats; go DONE with o_fault = 1 alongside o_done, o_rdata = 0.
- Undefined: no check; unaligned accesses proceed byte-by-byte from i_addr; o_fault tied 0.

## Structure
- Shared package/defs: size codes SZ_WORD/SZ_BYTE/SZ_HALF, state encodings, beat-count function.
- Sub-module mem_extend: combinational 32-bit extension from assembled bytes, size and sign.

## Test plan
- LB, addr 0x103, bus byte 0x80, ack always high -> 1 req beat at 0x103, o_done cycle k+2, o_rdata 0xFFFFFF80.
- LHU, addr 0x200, bytes 0x34,0x82, ack low 2 cycles on first beat -> addr holds 0x200, then 0x201, o_rdata 0x00008234, o_done k+5.
- SW, addr 0x10, wdata 0xDEADBEEF -> we=1 beats EF,BE,AD,DE at 0x10..0x13, o_done, o_rdata 0.
- LW at 0x12 -> with macro: no req, o_fault+o_done cycle k+1; without: 4 beats 0x12..0x15.
- Reset asserted during beat 2 of LW -> next cycle req 0, busy 0, no o_done; new LB afterwards completes normally.
- i_start pulsed while busy -> ignored; exactly one o_done for the first access.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM states and beat-count helper shared by the load/store unit.
package mem_access_pkg;
   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   function automatic logic [2:0] beats(input logic [1:0] size);
      return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/mem_extend.sv
// mem_extend: sign/zero extension of assembled load bytes to 32 bits.
module mem_extend
   import mem_access_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] ext
);
   always_comb
      ext = size == SZ_BYTE ? {{24{sign & data[7]}}, data[7:0]} :
            size == SZ_HALF ? {{16{sign & data[15]}}, data[15:0]} : data;
endmodule

// File: rtl/mem_access.sv
// mem_access: byte-serial load/store unit for the memory stage.
// MEMACC_ALIGN_CHECK_EN enables misalignment faulting of half/word accesses.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_memtoreg,
   input  logic              i_memwrite,
   input  logic [1:0]        i_insize,
   input  logic              i_insign,
   input  logic [1:0]        i_outsize,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_fault,
   output logic              o_bus_req,
   output logic              o_bus_we,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [7:0]        o_bus_wdata,
   input  logic [7:0]        i_bus_rdata,
   input  logic              i_bus_ack
);
   state_t state, next;
   logic [1:0] cnt, size, sz_in;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] wd, data, ext;
   logic sign, store, load, go, last, mis;

   // a store wins when both memtoreg and memwrite are set
   assign sz_in = i_memwrite ? i_outsize : i_insize;
   assign go = i_start && (i_memtoreg || i_memwrite);
   assign last = {1'b0, cnt} == beats(size) - 3'd1;

`ifdef MEMACC_ALIGN_CHECK_EN
   logic fault;
   assign mis = |(i_addr[1:0] & 2'(beats(sz_in) - 3'd1));
   assign o_fault = state == DONE && fault;
   always_ff @(posedge i_clk)
      if (i_rst) fault <= 1'b0;
      else if (state == IDLE && i_start) fault <= go && mis;
`else
   assign mis = 1'b0;
   assign o_fault = 1'b0;
`endif

   mem_extend u_ext (.data(data), .size(size), .sign(sign), .ext(ext));

   always_ff @(posedge i_clk) state <= i_rst ? IDLE : next;

   always_comb begin
      next = state;
      o_busy = state != IDLE || go;
      o_done = 1'b0;
      o_rdata = '0;
      o_bus_req = 1'b0;
      o_bus_we = 1'b0;
      o_bus_addr = '0;
      o_bus_wdata = '0;
      case (state)
         IDLE: if (i_start) next = go && !mis ? XFER : DONE;
         XFER: begin
            o_bus_req = 1'b1;
            o_bus_we = store;
            o_bus_addr = base + ADDR_W'(cnt);
            o_bus_wdata = wd[{cnt, 3'b000} +: 8];
            if (i_bus_ack && last) next = DONE;
         end
         default: begin
            o_done = 1'b1;
            o_rdata = load ? ext : '0;
            next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk)
      if (i_rst) begin
         cnt <= '0;
         base <= '0;
         wd <= '0;
         data <= '0;
         size <= SZ_WORD;
         sign <= 1'b0;
         store <= 1'b0;
         load <= 1'b0;
      end else if (state == IDLE && i_start) begin
         cnt <= '0;
         base <= i_addr;
         wd <= i_wdata;
         data <= '0;
         size <= sz_in;
         sign <= i_insign;
         store <= i_memwrite;
         load <= i_memtoreg && !i_memwrite;
      end else if (state == XFER && i_bus_ack) begin
         cnt <= cnt + 2'd1;
         if (load) data[{cnt, 3'b000} +: 8] <= i_bus_rdata;
      end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access with a byte-array bus model.
module tb_mem_access;
`ifdef MEMACC_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic clk = 0, rst = 1, start = 0, memtoreg = 0, memwrite = 0, insign = 0;
   logic [1:0] insize = 0, outsize = 0;
   logic [31:0] addr = 0, wdata = 0, rdata, bus_addr;
   logic busy, done, fault, bus_req, bus_we, bus_ack = 0;
   logic [7:0] bus_wdata, bus_rdata = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_memtoreg(memtoreg), .i_memwrite(memwrite),
      .i_insize(insize), .i_insign(insign), .i_outsize(outsize), .i_addr(addr), .i_wdata(wdata),
      .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_fault(fault), .o_bus_req(bus_req),
      .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
      .i_bus_rdata(bus_rdata), .i_bus_ack(bus_ack)
   );

   typedef struct {logic [31:0] addr; logic we; logic [7:0] wdata;} beat_t;
   typedef struct {logic [31:0] rdata; logic fault;} res_t;
   beat_t beat_q[$];
   res_t res_q[$];
   logic [7:0] mem[256];
   int checks = 0, fails = 0, stall_left = 0, nb;
   bit rand_ack = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // bus slave: byte memory, scripted stalls or random ack
   initial forever begin
      @(posedge clk);
      #1;
      bus_ack = bus_req && (rand_ack ? $urandom_range(0, 2) != 0 : stall_left == 0);
      if (bus_req && !rand_ack && stall_left > 0) stall_left--;
      bus_rdata = mem[bus_addr[7:0]];
   end

   initial forever begin : monitor
      beat_t b;
      res_t r;
      @(negedge clk);
      if (!rst) begin
         if (bus_req && bus_ack) begin
            if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               b = beat_q.pop_front();
               chk("beat_addr", bus_addr, b.addr);
               chk("beat_we", bus_we, b.we);
               chk("beat_wdata", bus_wdata, b.wdata);
            end
         end
         if (done) begin
            if (res_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               r = res_q.pop_front();
               chk("rdata", rdata, r.rdata);
               chk("fault", fault, r.fault);
            end
         end else if (fault) chk("fault_without_done", 1, 0);
      end
   end

   task automatic issue(input bit ld, input bit st, input logic [1:0] isz, input bit sg,
                        input logic [1:0] osz, input logic [31:0] a, input logic [31:0] wd,
                        output int n_beats);
      int t = 0, n;
      bit l, s, mis;
      longint v = 0;
      beat_t b;
      res_t r;
      @(negedge clk);
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("idle_timeout", 1, 0);
      s = st;
      l = ld && !st;
      n = (s ? osz : isz) == 2'd1 ? 1 : (s ? osz : isz) == 2'd2 ? 2 : 4;
      mis = ALIGN && (l || s) && (a % n != 0);
      n_beats = (l || s) && !mis ? n : 0;
      for (int i = 0; i < n_beats; i++) begin
         b.addr = a + 32'(i);
         b.we = s;
         b.wdata = 8'(wd >> (8 * i));
         beat_q.push_back(b);
      end
      if (l && !mis) begin
         for (int i = 0; i < n; i++) v = v | (longint'(mem[8'(a + 32'(i))]) << (8 * i));
         if (sg && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      end
      r.rdata = v[31:0];
      r.fault = mis;
      res_q.push_back(r);
      start = 1; memtoreg = ld; memwrite = st; insize = isz; insign = sg; outsize = osz;
      addr = a; wdata = wd;
      #1 chk("busy_on_start", busy, l || s);
      @(posedge clk);
      #1;
      start = 0;
      memtoreg = 1'($urandom); memwrite = 1'($urandom); insize = 2'($urandom);
      insign = 1'($urandom); outsize = 2'($urandom); addr = $urandom; wdata = $urandom;
   endtask

   // pokes i_start during XFER cycles to confirm it is ignored while busy
   task automatic wait_done(input int exp_lat, input bit poke);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
         start = poke && bus_req && $urandom_range(0, 3) == 0;
         memtoreg = 1;
      end while (!done && c < 200);
      start = 0;
      if (!done) chk("done_timeout", 1, 0);
      else if (exp_lat > 0) chk("latency", c, exp_lat);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_we", bus_we, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_wdata", bus_wdata, 0);
      rst = 0;
      mem[8'h03] = 8'h80;
      issue(1, 0, 2'd1, 1, 2'd0, 32'h103, 0, nb);
      wait_done(2, 0);
      mem[8'h00] = 8'h34;
      mem[8'h01] = 8'h82;
      stall_left = 2;
      issue(1, 0, 2'd2, 0, 2'd0, 32'h200, 0, nb);
      wait_done(5, 0);
      issue(0, 1, 2'd0, 0, 2'd0, 32'h10, 32'hDEADBEEF, nb);
      wait_done(5, 0);
      issue(1, 0, 2'd0, 1, 2'd0, 32'h12, 0, nb);
      wait_done(ALIGN ? 1 : 5, 0);
      issue(0, 0, 2'd1, 0, 2'd1, 32'h33, 0, nb);
      wait_done(1, 0);
      issue(1, 1, 2'd1, 1, 2'd2, 32'h20, 32'h0000A5C3, nb);
      wait_done(3, 0);
      issue(1, 0, 2'd0, 0, 2'd0, 32'h40, 0, nb);
      @(posedge clk);
      #2 chk("beat2_addr", bus_addr, 32'h41);
      rst = 1;
      beat_q.delete();
      res_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("midrst_req", bus_req, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_addr", bus_addr, 0);
      rst = 0;
      issue(1, 0, 2'd1, 0, 2'd0, 32'h77, 0, nb);
      wait_done(2, 0);
      rand_ack = 1;
      for (int k = 0; k < 40; k++) begin
         logic [1:0] op;
         logic [31:0] a;
         op = 2'($urandom);
         a = $urandom_range(0, 4) == 0 ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
         issue(op[0], op[1], 2'($urandom_range(0, 2)), 1'($urandom), 2'($urandom_range(0, 2)),
               a, $urandom, nb);
         wait_done(0, 1);
      end
      repeat (5) @(negedge clk);
      chk("beat_q_empty", beat_q.size(), 0);
      chk("res_q_empty", res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
